// File: rtl/cpu_sequencer_if.sv
// Control and status bundle between the CPU datapath/control generator and the sequencer.
// The master side drives the phase-control inputs and the instruction register; the slave side is the sequencer.
interface cpu_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             sm_en;
    logic             run;
    logic             step;
    logic             resume;
    logic [7:0]       ir;
    logic             sm;
    logic             mova;
    logic             movb;
    logic             movc;
    logic             movd;
    logic             add;
    logic             sub;
    logic             jmp;
    logic             jg;
    logic             in1;
    logic             out1;
    logic             movi;
    logic             halt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output sm_en, run, step, resume, ir,
        input  sm, mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt, instr_cnt
    );

    modport slave (
        input  sm_en, run, step, resume, ir,
        output sm, mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt, instr_cnt
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Two-phase FETCH/EXEC sequencer with opcode decode, halt, single-step and retired-instruction count.
// Strobes are combinational from state and ir (zero latency); sm_en=0 stretches the current phase.
module cpu_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_step_q;
    logic             r_step_pend;
    logic [CNT_W-1:0] r_instr_cnt;

    logic       w_take_exec;
    logic       w_retire;
    logic       w_step_rise;
    logic       w_step_pend_nxt;
    logic       w_exec;
    logic [3:0] w_opcode;

    assign w_opcode    = bus.ir[7:4];
    assign w_exec      = (r_state == ST_EXEC);
    assign w_step_rise = bus.step & ~r_step_q;

    always_comb begin
        w_next_state = r_state;
        w_take_exec  = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (bus.sm_en && (bus.run || r_step_pend)) begin
                    w_next_state = ST_EXEC;
                    w_take_exec  = 1'b1;
                end
            end
            ST_EXEC: begin
                // HALT retires even when the control generator is stalling us.
                if (w_opcode == OP_HALT) begin
                    w_next_state = ST_HALTED;
                    w_retire     = 1'b1;
                end else if (bus.sm_en) begin
                    w_next_state = ST_FETCH;
                    w_retire     = 1'b1;
                end
            end
            ST_HALTED: begin
                if (bus.resume) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = ST_FETCH;
        endcase
    end

    // A new step edge outranks the clear from the FETCH->EXEC it may coincide with.
    always_comb begin
        w_step_pend_nxt = r_step_pend;
        if (w_step_rise) begin
            w_step_pend_nxt = 1'b1;
        end else if (w_take_exec) begin
            w_step_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_step_q    <= 1'b0;
            r_step_pend <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_step_q    <= bus.step;
            r_step_pend <= w_step_pend_nxt;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.sm        = (r_state != ST_FETCH);
    assign bus.mova      = w_exec && (w_opcode == 4'h0);
    assign bus.movb      = w_exec && (w_opcode == 4'h1);
    assign bus.movc      = w_exec && (w_opcode == 4'h2);
    assign bus.movd      = w_exec && (w_opcode == 4'h3);
    assign bus.add       = w_exec && (w_opcode == 4'h4);
    assign bus.sub       = w_exec && (w_opcode == 4'h5);
    assign bus.jmp       = w_exec && (w_opcode == 4'h6);
    assign bus.jg        = w_exec && (w_opcode == 4'h7);
    assign bus.in1       = w_exec && (w_opcode == 4'h8);
    assign bus.out1      = w_exec && (w_opcode == 4'h9);
    assign bus.movi      = w_exec && (w_opcode == 4'hA);
    assign bus.halt      = (w_exec && (w_opcode == OP_HALT)) || (r_state == ST_HALTED);
    assign bus.instr_cnt = r_instr_cnt;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, free-run, opcode sweep, halt/resume, single-step, stretch, wrap, mid-EXEC reset.
module tb_cpu_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cpu_sequencer_if #(.CNT_W(8)) bus ();

    cpu_sequencer #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector, bit order: {halt, movi, out1, in1, jg, jmp, sub, add, movd, movc, movb, mova}
    function automatic logic [11:0] strb();
        return {bus.halt, bus.movi, bus.out1, bus.in1, bus.jg, bus.jmp,
                bus.sub, bus.add, bus.movd, bus.movc, bus.movb, bus.mova};
    endfunction

    function automatic logic [11:0] exp_strb(input logic [3:0] op);
        case (op)
            4'h0: return 12'h001;
            4'h1: return 12'h002;
            4'h2: return 12'h004;
            4'h3: return 12'h008;
            4'h4: return 12'h010;
            4'h5: return 12'h020;
            4'h6: return 12'h040;
            4'h7: return 12'h080;
            4'h8: return 12'h100;
            4'h9: return 12'h200;
            4'hA: return 12'h400;
            4'hF: return 12'h800;
            default: return 12'h000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.sm_en  = 1'b0;
        bus.run    = 1'b0;
        bus.step   = 1'b0;
        bus.resume = 1'b0;
        bus.ir     = 8'h00;
        tick();
        tick();
        chk("reset_sm", 32'(bus.sm), 32'd0);
        chk("reset_strb", 32'(strb()), 32'd0);
        chk("reset_cnt", 32'(bus.instr_cnt), 32'd0);
        rst = 1'b0;

        // Free run with ADD
        bus.run   = 1'b1;
        bus.sm_en = 1'b1;
        bus.ir    = 8'h45;
        tick();
        chk("run_sm1", 32'(bus.sm), 32'd1);
        chk("run_add1", 32'(strb()), 32'h010);
        tick();
        chk("run_sm0", 32'(bus.sm), 32'd0);
        chk("run_strb0", 32'(strb()), 32'd0);
        chk("run_cnt1", 32'(bus.instr_cnt), 32'd1);
        tick();
        chk("run_sm1b", 32'(bus.sm), 32'd1);
        chk("run_add1b", 32'(strb()), 32'h010);
        tick();
        chk("run_sm0b", 32'(bus.sm), 32'd0);
        chk("run_cnt2", 32'(bus.instr_cnt), 32'd2);

        // Opcode sweep 0x0..0xE (HALT handled separately)
        for (int op = 0; op < 15; op++) begin
            bus.ir = {4'(op), 4'h3};
            tick();
            chk($sformatf("sweep_sm_op%0h", op), 32'(bus.sm), 32'd1);
            chk($sformatf("sweep_strb_op%0h", op), 32'(strb()), 32'(exp_strb(4'(op))));
            tick();
            chk($sformatf("sweep_cnt_op%0h", op), 32'(bus.instr_cnt), 32'(3 + op));
        end

        // HALT; resume during EXEC(halt) must not matter
        bus.ir = 8'hF0;
        tick();
        bus.run = 1'b0;
        chk("halt_exec_strb", 32'(strb()), 32'h800);
        chk("halt_exec_cnt", 32'(bus.instr_cnt), 32'd17);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk("halted_sm", 32'(bus.sm), 32'd1);
        chk("halted_cnt", 32'(bus.instr_cnt), 32'd18);
        bus.sm_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("halted_hold%0d", i), 32'({bus.sm, bus.halt}), 32'b11);
        end
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        bus.sm_en  = 1'b1;
        chk("resume_sm", 32'(bus.sm), 32'd0);
        chk("resume_halt", 32'(bus.halt), 32'd0);

        // Single-step
        bus.ir = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("step_hold%0d", i), 32'(bus.sm), 32'd0);
        end
        bus.step = 1'b1;
        tick();
        chk("step_edgeN", 32'(bus.sm), 32'd0);
        tick();
        chk("step_exec_sm", 32'(bus.sm), 32'd1);
        chk("step_exec_strb", 32'(strb()), 32'h002);
        tick();
        chk("step_back_sm", 32'(bus.sm), 32'd0);
        chk("step_cnt", 32'(bus.instr_cnt), 32'd19);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("step_noretrig%0d", i), 32'(bus.sm), 32'd0);
        end
        bus.step = 1'b0;

        // sm_en stretch of EXEC(SUB)
        bus.ir  = 8'h50;
        bus.run = 1'b1;
        tick();
        chk("stretch_entry", 32'(strb()), 32'h020);
        bus.sm_en = 1'b0;
        bus.run   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stretch_sub%0d", i), 32'({bus.sm, strb()}), 32'h1020);
            chk($sformatf("stretch_cnt%0d", i), 32'(bus.instr_cnt), 32'd19);
        end
        bus.sm_en = 1'b1;
        tick();
        chk("stretch_exit_sm", 32'(bus.sm), 32'd0);
        chk("stretch_exit_cnt", 32'(bus.instr_cnt), 32'd20);

        // Run NOPs to 255, then one more wraps to 0
        bus.ir  = 8'hC0;
        bus.run = 1'b1;
        for (int i = 0; i < 470; i++) tick();
        chk("wrap_pre_sm", 32'(bus.sm), 32'd0);
        chk("wrap_pre_cnt", 32'(bus.instr_cnt), 32'd255);
        tick();
        tick();
        chk("wrap_cnt", 32'(bus.instr_cnt), 32'd0);

        // Reset mid-EXEC
        bus.ir = 8'h60;
        tick();
        chk("rst_pre_strb", 32'(strb()), 32'h040);
        rst = 1'b1;
        tick();
        chk("rst_exec_sm", 32'(bus.sm), 32'd0);
        chk("rst_exec_strb", 32'(strb()), 32'd0);
        rst     = 1'b0;
        bus.run = 1'b0;
        tick();
        chk("rst_after_cnt", 32'(bus.instr_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
